// File: rtl/muller_c_pkg.sv
// Shared defaults and io_in bit-mapping helper for the muller_c C-element bank.
package muller_c_pkg;

    localparam int DEF_LANES = 3;
    localparam int DEF_CNT_W = 8;

    typedef struct packed {
        int a_pos;
        int b_pos;
    } lane_idx_t;

    // Lane i is fed from a pair of adjacent io_in bits: a at 2i, b at 2i+1.
    function automatic lane_idx_t lane_io_idx(input int lane);
        lane_idx_t idx;
        idx.a_pos = 2 * lane;
        idx.b_pos = 2 * lane + 1;
        return idx;
    endfunction

endpackage

// File: rtl/muller_c_lane.sv
// One clocked two-input C-element with transition counter and sticky
// handshake-withdrawal detector.
module muller_c_lane
    import muller_c_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             hazard,
    output logic [CNT_W-1:0] cnt
);

    logic pending;
    logic agree;
    logic fire;
    logic withdraw;

    assign agree    = (a == b);
    assign fire     = agree && (a != c);
    // One input had moved away last edge and has now come back to c.
    assign withdraw = pending && agree && (a == c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c       <= 1'b0;
            pending <= 1'b0;
            hazard  <= 1'b0;
            cnt     <= '0;
        end else begin
            pending <= a ^ b;
            if (agree)
                c <= a;
            if (fire)
                cnt <= cnt + CNT_W'(1);
            if (withdraw)
                hazard <= 1'b1;
        end
    end

endmodule

// File: rtl/muller_c_proj_formal_top.sv
// Bank of LANES clocked C-elements fed from packed io_in, plus all-high/all-low
// reductions of the lane states.
module muller_c_proj_formal_top
    import muller_c_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*LANES-1:0]     io_in,
    output logic [LANES-1:0]       io_out,
    output logic                   all_high,
    output logic                   all_low,
    output logic [LANES-1:0]       hazard,
    output logic [LANES*CNT_W-1:0] trans_cnt
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam lane_idx_t IDX = lane_io_idx(i);

        muller_c_lane #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .a      (io_in[IDX.a_pos]),
            .b      (io_in[IDX.b_pos]),
            .c      (io_out[i]),
            .hazard (hazard[i]),
            .cnt    (trans_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign all_high = &io_out;
    assign all_low  = ~|io_out;

endmodule

// File: tb/tb_muller_c_proj_formal_top.sv
// Directed bench for the C-element bank: agreement/hold, withdrawal hazard,
// counter wrap, async reset and simultaneous toggles.
module tb_muller_c_proj_formal_top;

    localparam int LANES = 3;
    localparam int CNT_W = 8;

    logic                   clk;
    logic                   rst;
    logic [2*LANES-1:0]     io_in;
    logic [LANES-1:0]       io_out;
    logic                   all_high;
    logic                   all_low;
    logic [LANES-1:0]       hazard;
    logic [LANES*CNT_W-1:0] trans_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    muller_c_proj_formal_top #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io_in     (io_in),
        .io_out    (io_out),
        .all_high  (all_high),
        .all_low   (all_low),
        .hazard    (hazard),
        .trans_cnt (trans_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        io_in = '0;
        #12;
        chk("rst_out",    32'(io_out),    32'h0);
        chk("rst_haz",    32'(hazard),    32'h0);
        chk("rst_cnt",    32'(trans_cnt), 32'h0);
        chk("rst_alllow", 32'(all_low),   32'h1);
        chk("rst_allhi",  32'(all_high),  32'h0);
        rst = 1'b0;

        // lane0 agrees at 0, lanes 1,2 disagree
        io_in = 6'b010100;
        tick();
        chk("s1_out", 32'(io_out),    32'h0);
        chk("s1_haz", 32'(hazard),    32'h0);
        chk("s1_cnt", 32'(trans_cnt), 32'h0);

        io_in = 6'b111111;
        tick();
        chk("s2_out",    32'(io_out),    32'h7);
        chk("s2_allhi",  32'(all_high),  32'h1);
        chk("s2_alllow", 32'(all_low),   32'h0);
        chk("s2_cnt",    32'(trans_cnt), 32'h010101);
        chk("s2_haz",    32'(hazard),    32'h0);

        io_in = 6'b101010;
        tick();
        chk("hold_out", 32'(io_out),    32'h7);
        chk("hold_haz", 32'(hazard),    32'h0);
        chk("hold_cnt", 32'(trans_cnt), 32'h010101);

        // normal completion back to 0 must not flag a hazard
        io_in = 6'b000000;
        tick();
        chk("dn_out", 32'(io_out),    32'h0);
        chk("dn_haz", 32'(hazard),    32'h0);
        chk("dn_cnt", 32'(trans_cnt), 32'h020202);

        // lane0 withdrawal: a rises then falls back before b follows
        io_in = 6'b000001;
        tick();
        chk("wd1_out", 32'(io_out), 32'h0);
        chk("wd1_haz", 32'(hazard), 32'h0);
        io_in = 6'b000000;
        tick();
        chk("wd2_haz", 32'(hazard),    32'h1);
        chk("wd2_out", 32'(io_out),    32'h0);
        chk("wd2_cnt", 32'(trans_cnt), 32'h020202);
        tick();
        chk("wd3_sticky", 32'(hazard), 32'h1);

        io_in = 6'b111111;
        tick();
        chk("pre_rst_out", 32'(io_out),    32'h7);
        chk("pre_rst_haz", 32'(hazard),    32'h1);
        chk("pre_rst_cnt", 32'(trans_cnt), 32'h030303);

        // async reset mid-cycle, checked before the next rising edge
        rst = 1'b1;
        #1;
        chk("arst_out", 32'(io_out),    32'h0);
        chk("arst_haz", 32'(hazard),    32'h0);
        chk("arst_cnt", 32'(trans_cnt), 32'h0);
        #2;
        io_in = 6'b000000;
        rst   = 1'b0;
        tick();
        chk("post_rst_out", 32'(io_out),    32'h0);
        chk("post_rst_haz", 32'(hazard),    32'h0);
        chk("post_rst_cnt", 32'(trans_cnt), 32'h0);

        // 256 toggles on lane1: counter passes 255 and wraps to 0
        for (int k = 1; k <= 256; k++) begin
            io_in = (k % 2 == 1) ? 6'b001100 : 6'b000000;
            tick();
            if (k == 255) begin
                chk("tg255_cnt1", 32'(trans_cnt[CNT_W +: CNT_W]), 32'd255);
                chk("tg255_out",  32'(io_out), 32'h2);
            end
        end
        chk("tgwrap_cnt1", 32'(trans_cnt[CNT_W +: CNT_W]), 32'd0);
        chk("tgwrap_out",  32'(io_out),    32'h0);
        chk("tgwrap_haz",  32'(hazard),    32'h0);
        chk("tgwrap_cnt",  32'(trans_cnt), 32'h0);

        // lane2 both inputs rise together
        #2;
        io_in = 6'b110000;
        #1;
        chk("sim_pre_out", 32'(io_out), 32'h0);
        tick();
        chk("sim_out",  32'(io_out),    32'h4);
        chk("sim_haz",  32'(hazard),    32'h0);
        chk("sim_cnt",  32'(trans_cnt), 32'h010000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
